// File: rtl/fir_sched_ctrl_if.sv
// Handshake/bus bundle between the FIR sequencer and its surroundings:
// AXI-lite start/length and tap-config requests, AXI-Stream handshakes,
// tap/data BRAM control and MAC control.
// The master modport is the sequencer; the slave modport is the environment.
interface fir_sched_ctrl_if #(
    parameter int pADDR_WIDTH = 12
);
    logic                   ap_start;
    logic [31:0]            data_length;
    logic                   ap_done;
    logic                   ap_idle;

    logic                   ss_tvalid;
    logic                   ss_tlast;
    logic                   ss_tready;
    logic                   sm_tvalid;
    logic                   sm_tready;
    logic                   sm_tlast;

    logic                   cfg_tap_req;
    logic                   cfg_tap_we;
    logic [pADDR_WIDTH-1:0] cfg_tap_addr;
    logic                   cfg_tap_gnt;

    logic                   tap_EN;
    logic [3:0]             tap_WE;
    logic [pADDR_WIDTH-1:0] tap_A;
    logic                   data_EN;
    logic [3:0]             data_WE;
    logic [pADDR_WIDTH-1:0] data_A;
    logic                   data_sel_zero;

    logic                   mac_clr;
    logic                   mac_en;

    modport master (
        input  ap_start, data_length, ss_tvalid, ss_tlast, sm_tready,
               cfg_tap_req, cfg_tap_we, cfg_tap_addr,
        output ap_done, ap_idle, ss_tready, sm_tvalid, sm_tlast, cfg_tap_gnt,
               tap_EN, tap_WE, tap_A, data_EN, data_WE, data_A, data_sel_zero,
               mac_clr, mac_en
    );

    modport slave (
        output ap_start, data_length, ss_tvalid, ss_tlast, sm_tready,
               cfg_tap_req, cfg_tap_we, cfg_tap_addr,
        input  ap_done, ap_idle, ss_tready, sm_tvalid, sm_tlast, cfg_tap_gnt,
               tap_EN, tap_WE, tap_A, data_EN, data_WE, data_A, data_sel_zero,
               mac_clr, mac_en
    );
endinterface

// File: rtl/fir_sched_ctrl.sv
// Control-path sequencer for the Tape_Num-tap FIR engine.
// Runs ap_start/ap_done/ap_idle, clears and addresses the circular data BRAM,
// steps the tap BRAM, drives MAC clear/enable and the AXI-Stream handshakes,
// and lends the tap BRAM to the AXI-lite config path while idle.
// All outputs are registered and always reflect the current FSM state.
// Optional feature: define FIR_SCHED_TLAST_CHECK_EN to add the sticky
// tlast_err output that flags inputs whose ss_tlast disagrees with data_length.
module fir_sched_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int Tape_Num    = 11
) (
    input  logic axis_clk,
    input  logic axis_rst,
`ifdef FIR_SCHED_TLAST_CHECK_EN
    output logic tlast_err,
`endif
    fir_sched_ctrl_if.master bus
);
    localparam int               IDX_W    = $clog2(Tape_Num);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Tape_Num - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT_IN, S_WRITE, S_MAC, S_DRAIN, S_OUT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;        // CLEAR address / MAC tap index
    logic [IDX_W-1:0] didx;       // MAC data index, walks backwards from head
    logic [IDX_W-1:0] head;       // slot of the newest sample
    logic [31:0]      len;
    logic [31:0]      out_cnt;
    logic             start_pend; // holds an ap_start that lost to a cfg request
`ifdef FIR_SCHED_TLAST_CHECK_EN
    logic [31:0]      in_cnt;
`endif

    function automatic logic [pADDR_WIDTH-1:0] byte_addr(input logic [IDX_W-1:0] i);
        byte_addr = pADDR_WIDTH'(i) << 2;
    endfunction

    // Circular-buffer step towards older samples.
    function automatic logic [IDX_W-1:0] dec_wrap(input logic [IDX_W-1:0] i);
        dec_wrap = (i == '0) ? LAST_IDX : i - IDX_W'(1);
    endfunction

    // Sequencer FSM with registered outputs and tap-BRAM arbitration.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state             <= S_IDLE;
            bus.ss_tready     <= 1'b0;
            bus.sm_tvalid     <= 1'b0;
            bus.sm_tlast      <= 1'b0;
            bus.tap_EN        <= 1'b0;
            bus.tap_WE        <= 4'h0;
            bus.data_EN       <= 1'b0;
            bus.data_WE       <= 4'h0;
            bus.data_sel_zero <= 1'b0;
            bus.mac_clr       <= 1'b0;
            bus.mac_en        <= 1'b0;
            bus.cfg_tap_gnt   <= 1'b0;
            bus.ap_done       <= 1'b0;
            bus.ap_idle       <= 1'b1;
            head              <= '0;
            out_cnt           <= '0;
            start_pend        <= 1'b0;
`ifdef FIR_SCHED_TLAST_CHECK_EN
            tlast_err         <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // A config request always wins; the start waits in start_pend.
                    if ((start_pend || bus.ap_start) && !bus.cfg_tap_req) begin
                        state             <= S_CLEAR;
                        start_pend        <= 1'b0;
                        bus.ap_done       <= 1'b0;
                        bus.ap_idle       <= 1'b0;
                        len               <= bus.data_length;
                        out_cnt           <= '0;
                        head              <= '0;
                        idx               <= '0;
                        bus.cfg_tap_gnt   <= 1'b0;
                        bus.tap_EN        <= 1'b0;
                        bus.tap_WE        <= 4'h0;
                        bus.data_EN       <= 1'b1;
                        bus.data_WE       <= 4'hF;
                        bus.data_sel_zero <= 1'b1;
                        bus.data_A        <= byte_addr('0);
`ifdef FIR_SCHED_TLAST_CHECK_EN
                        tlast_err         <= 1'b0;
                        in_cnt            <= '0;
`endif
                    end else begin
                        start_pend      <= start_pend || bus.ap_start;
                        bus.cfg_tap_gnt <= bus.cfg_tap_req;
                        bus.tap_EN      <= bus.cfg_tap_req;
                        bus.tap_WE      <= (bus.cfg_tap_req && bus.cfg_tap_we) ? 4'hF : 4'h0;
                        bus.tap_A       <= bus.cfg_tap_addr;
                    end
                end
                S_CLEAR: begin
                    // Zero the whole history so each run starts from silence.
                    if (idx == LAST_IDX) begin
                        bus.data_EN       <= 1'b0;
                        bus.data_WE       <= 4'h0;
                        bus.data_sel_zero <= 1'b0;
                        if (len == '0) begin
                            state       <= S_IDLE;
                            bus.ap_done <= 1'b1;
                            bus.ap_idle <= 1'b1;
                        end else begin
                            state         <= S_WAIT_IN;
                            bus.ss_tready <= 1'b1;
                        end
                    end else begin
                        idx        <= idx + IDX_W'(1);
                        bus.data_A <= byte_addr(idx + IDX_W'(1));
                    end
                end
                S_WAIT_IN: begin
                    if (bus.ss_tvalid) begin
                        state         <= S_WRITE;
                        bus.ss_tready <= 1'b0;
                        bus.data_EN   <= 1'b1;
                        bus.data_WE   <= 4'hF;
                        bus.data_A    <= byte_addr(head);
                        bus.mac_clr   <= 1'b1;
`ifdef FIR_SCHED_TLAST_CHECK_EN
                        if (bus.ss_tlast != (in_cnt == len - 32'd1))
                            tlast_err <= 1'b1;
                        in_cnt <= in_cnt + 32'd1;
`endif
                    end
                end
                S_WRITE: begin
                    state       <= S_MAC;
                    bus.mac_clr <= 1'b0;
                    bus.data_WE <= 4'h0;
                    bus.data_A  <= byte_addr(head);
                    bus.tap_EN  <= 1'b1;
                    bus.tap_WE  <= 4'h0;
                    bus.tap_A   <= byte_addr('0);
                    idx         <= '0;
                    didx        <= head;
                end
                S_MAC: begin
                    // Read data lands one cycle later, so mac_en trails the address by one.
                    bus.mac_en <= 1'b1;
                    if (idx == LAST_IDX) begin
                        state       <= S_DRAIN;
                        bus.tap_EN  <= 1'b0;
                        bus.data_EN <= 1'b0;
                    end else begin
                        idx        <= idx + IDX_W'(1);
                        bus.tap_A  <= byte_addr(idx + IDX_W'(1));
                        didx       <= dec_wrap(didx);
                        bus.data_A <= byte_addr(dec_wrap(didx));
                    end
                end
                S_DRAIN: begin
                    state         <= S_OUT;
                    bus.mac_en    <= 1'b0;
                    head          <= (head == LAST_IDX) ? '0 : head + IDX_W'(1);
                    bus.sm_tvalid <= 1'b1;
                    bus.sm_tlast  <= (out_cnt == len - 32'd1);
                end
                S_OUT: begin
                    if (bus.sm_tready) begin
                        bus.sm_tvalid <= 1'b0;
                        bus.sm_tlast  <= 1'b0;
                        out_cnt       <= out_cnt + 32'd1;
                        if (out_cnt == len - 32'd1) begin
                            state       <= S_IDLE;
                            bus.ap_done <= 1'b1;
                            bus.ap_idle <= 1'b1;
                        end else begin
                            state         <= S_WAIT_IN;
                            bus.ss_tready <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_sched_ctrl.sv
// Testbench for fir_sched_ctrl. Surrounds the sequencer with a behavioural
// tap BRAM, data BRAM and MAC, and compares streamed results with a direct
// convolution of the input against the taps (zero history at run start).
`timescale 1ns/1ps
module tb_fir_sched_ctrl;
    localparam int TAPS = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_sched_ctrl_if #(.pADDR_WIDTH(12)) bus ();
`ifdef FIR_SCHED_TLAST_CHECK_EN
    logic tlast_err;
`endif

    fir_sched_ctrl #(.pADDR_WIDTH(12), .Tape_Num(TAPS)) dut (
        .axis_clk (clk),
        .axis_rst (rst),
`ifdef FIR_SCHED_TLAST_CHECK_EN
        .tlast_err(tlast_err),
`endif
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    int h [TAPS] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int xin [];
    int gold [];

    // Behavioural datapath around the sequencer
    logic signed [31:0] ss_tdata, cfg_wdata, sample_q, tap_do, data_do, acc;
    logic signed [31:0] tap_mem [TAPS];
    logic signed [31:0] data_mem [TAPS];

    always @(posedge clk) begin
        if (bus.ss_tvalid && bus.ss_tready) sample_q <= ss_tdata;
        if (bus.tap_EN) begin
            if (bus.tap_WE == 4'hF) tap_mem[bus.tap_A[11:2]] <= cfg_wdata;
            tap_do <= tap_mem[bus.tap_A[11:2]];
        end
        if (bus.data_EN) begin
            if (bus.data_WE == 4'hF) data_mem[bus.data_A[11:2]] <= bus.data_sel_zero ? 32'sd0 : sample_q;
            data_do <= data_mem[bus.data_A[11:2]];
        end
        if (bus.mac_clr) acc <= 32'sd0;
        else if (bus.mac_en) acc <= acc + tap_do * data_do;
    end

    task automatic gen_input(input int n, input int xmode);
        xin = new[n];
        gold = new[n];
        for (int i = 0; i < n; i++) begin
            if (xmode == 0) begin
                int v = i % 40;
                xin[i] = ((v < 20) ? v : 40 - v) * 25 - 250;
            end else begin
                xin[i] = int'($urandom_range(0, 2000)) - 1000;
            end
        end
        for (int i = 0; i < n; i++) begin
            int s = 0;
            for (int k = 0; k < TAPS; k++)
                if (i - k >= 0) s += h[k] * xin[i - k];
            gold[i] = s;
        end
    endtask

    // rmode 0: always ready/valid; 1: sm_tready 1-of-3, ss_tvalid random
    // tmode 0: correct tlast; 1: extra tlast on sample 10; 2: random tlast
    task automatic run_stream(input int n, input bit do_start, input int rmode, input int tmode);
        int in_idx = 0, out_idx = 0, clr_cnt = 0, mac_cnt = 0, cyc = 0;
        bit pend = 0;
        bus.data_length = n;
        if (do_start) begin
            @(negedge clk); bus.ap_start = 1'b1;
            @(negedge clk); bus.ap_start = 1'b0;
        end
        while (out_idx < n && cyc < 30 * n + 200) begin
            @(negedge clk);
            cyc++;
            if (bus.mac_clr) begin
                checks++;
                if (bus.data_A !== 12'(4 * (clr_cnt % TAPS))) begin
                    errors++;
                    $display("FAIL write_addr sample %0d got %0d want %0d", clr_cnt, bus.data_A, 4 * (clr_cnt % TAPS));
                end
                clr_cnt++;
                mac_cnt = 0;
            end
            if (bus.mac_en) mac_cnt++;
            checks++;
            if (bus.ap_idle !== 1'b0) begin
                errors++;
                $display("FAIL idle_in_run cycle %0d got %0b want 0", cyc, bus.ap_idle);
            end
            if (bus.cfg_tap_req) begin
                checks++;
                if (bus.cfg_tap_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL gnt_in_run cycle %0d got %0b want 0", cyc, bus.cfg_tap_gnt);
                end
            end
            if (bus.ss_tready) begin
                checks++;
                if (bus.ap_done !== 1'b0) begin
                    errors++;
                    $display("FAIL done_in_run got %0b want 0", bus.ap_done);
                end
            end
            if (pend) begin
                checks++;
                if (bus.sm_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL sm_tvalid_hold out %0d got %0b want 1", out_idx, bus.sm_tvalid);
                end
            end
            bus.sm_tready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (bus.ss_tready && in_idx < n && (rmode == 0 || $urandom_range(0, 1) == 1)) begin
                bus.ss_tvalid = 1'b1;
                ss_tdata = xin[in_idx];
                case (tmode)
                    1:       bus.ss_tlast = (in_idx == n - 1) || (in_idx == 10);
                    2:       bus.ss_tlast = 1'($urandom_range(0, 1));
                    default: bus.ss_tlast = (in_idx == n - 1);
                endcase
                in_idx++;
            end else begin
                bus.ss_tvalid = 1'b0;
                bus.ss_tlast = 1'b0;
            end
            if (bus.sm_tvalid && bus.sm_tready) begin
                checks++;
                if (acc !== gold[out_idx]) begin
                    errors++;
                    $display("FAIL fir_out %0d got %0d want %0d", out_idx, acc, gold[out_idx]);
                end
                checks++;
                if (bus.sm_tlast !== (out_idx == n - 1)) begin
                    errors++;
                    $display("FAIL sm_tlast out %0d got %0b want %0b", out_idx, bus.sm_tlast, out_idx == n - 1);
                end
                checks++;
                if (mac_cnt != TAPS) begin
                    errors++;
                    $display("FAIL mac_pulses out %0d got %0d want %0d", out_idx, mac_cnt, TAPS);
                end
                out_idx++;
                pend = 0;
            end else begin
                pend = bus.sm_tvalid;
            end
        end
        bus.ss_tvalid = 1'b0;
        checks++;
        if (out_idx != n) begin
            errors++;
            $display("FAIL run_timeout outputs got %0d want %0d", out_idx, n);
        end
        @(negedge clk);
        checks++;
        if (bus.ap_done !== 1'b1 || bus.ap_idle !== 1'b1) begin
            errors++;
            $display("FAIL run_end done/idle got %0b/%0b want 1/1", bus.ap_done, bus.ap_idle);
        end
        checks++;
        if (bus.ss_tready !== 1'b0 || bus.sm_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL run_end handshakes got %0b/%0b want 0/0", bus.ss_tready, bus.sm_tvalid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done_idle got %0b/%0b want 0/1", bus.ap_done, bus.ap_idle);
        end
        checks++;
        if ({bus.ss_tready, bus.sm_tvalid, bus.sm_tlast} !== 3'b000) begin
            errors++;
            $display("FAIL reset_axis got %b want 000", {bus.ss_tready, bus.sm_tvalid, bus.sm_tlast});
        end
        checks++;
        if ({bus.tap_EN, bus.tap_WE, bus.data_EN, bus.data_WE} !== 10'd0) begin
            errors++;
            $display("FAIL reset_bram got %b want 0", {bus.tap_EN, bus.tap_WE, bus.data_EN, bus.data_WE});
        end
        checks++;
        if ({bus.mac_clr, bus.mac_en, bus.cfg_tap_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mac_gnt got %b want 000", {bus.mac_clr, bus.mac_en, bus.cfg_tap_gnt});
        end
`ifdef FIR_SCHED_TLAST_CHECK_EN
        checks++;
        if (tlast_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_tlast_err got %0b want 0", tlast_err);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_taps();
        int wt;
        for (int k = 0; k < TAPS; k++) begin
            @(negedge clk);
            bus.cfg_tap_req = 1'b1;
            bus.cfg_tap_we = 1'b1;
            bus.cfg_tap_addr = 12'(4 * k);
            cfg_wdata = h[k];
            wt = 0;
            do begin
                @(negedge clk);
                wt++;
            end while (!bus.cfg_tap_gnt && wt < 10);
            checks++;
            if (bus.cfg_tap_gnt !== 1'b1 || bus.tap_WE !== 4'hF || bus.tap_EN !== 1'b1) begin
                errors++;
                $display("FAIL tap_load %0d gnt/EN/WE got %0b/%0b/%h want 1/1/f", k, bus.cfg_tap_gnt, bus.tap_EN, bus.tap_WE);
            end
            bus.cfg_tap_req = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_full_run();
        gen_input(600, 0);
        run_stream(600, 1, 0, 0);
    endtask

    task automatic test_ready_toggle();
        gen_input(600, 0);
        run_stream(600, 1, 1, 2);
    endtask

    task automatic test_back_to_back();
        gen_input(40, 1);
        for (int r = 0; r < 3; r++) run_stream(40, 1, r == 1 ? 1 : 0, 0);
    endtask

    task automatic test_zero_len();
        int cyc = 1;
        bit saw_ready = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ap_done !== 1'b1) begin
            errors++;
            $display("FAIL done_sticky got %0b want 1", bus.ap_done);
        end
        bus.data_length = 0;
        @(negedge clk); bus.ap_start = 1'b1;
        @(negedge clk); bus.ap_start = 1'b0;
        checks++;
        if (bus.ap_done !== 1'b0 || bus.ap_idle !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_accept done/idle got %0b/%0b want 0/0", bus.ap_done, bus.ap_idle);
        end
        while (!bus.ap_done && cyc < 40) begin
            if (bus.ss_tready) saw_ready = 1;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bus.ap_done !== 1'b1 || bus.ap_idle !== 1'b1 || saw_ready) begin
            errors++;
            $display("FAIL zero_len_end done/idle/ready got %0b/%0b/%0b want 1/1/0", bus.ap_done, bus.ap_idle, saw_ready);
        end
        checks++;
        if (cyc < TAPS) begin
            errors++;
            $display("FAIL zero_len_clear cycles got %0d want >=%0d", cyc, TAPS);
        end
    endtask

    task automatic test_cfg_arbiter();
        int wt = 0;
        gen_input(4, 1);
        bus.data_length = 4;
        @(negedge clk); bus.ap_start = 1'b1;
        @(negedge clk); bus.ap_start = 1'b0;
        @(negedge clk);
        bus.cfg_tap_req = 1'b1;
        bus.cfg_tap_we = 1'b0;
        bus.cfg_tap_addr = 12'h008;
        run_stream(4, 0, 1, 0);
        while (!bus.cfg_tap_gnt && wt < 5) begin
            @(negedge clk);
            wt++;
        end
        checks++;
        if (bus.cfg_tap_gnt !== 1'b1 || bus.tap_EN !== 1'b1 || bus.tap_WE !== 4'h0 || bus.tap_A !== 12'h008) begin
            errors++;
            $display("FAIL gnt_after_run gnt/EN/WE/A got %0b/%0b/%h/%h want 1/1/0/008", bus.cfg_tap_gnt, bus.tap_EN, bus.tap_WE, bus.tap_A);
        end
        bus.cfg_tap_req = 1'b0;
        @(negedge clk);
        gen_input(3, 1);
        bus.data_length = 3;
        bus.cfg_tap_req = 1'b1;
        bus.ap_start = 1'b1;
        @(negedge clk);
        bus.ap_start = 1'b0;
        checks++;
        if (bus.cfg_tap_gnt !== 1'b1 || bus.ap_idle !== 1'b1) begin
            errors++;
            $display("FAIL req_start_gnt gnt/idle got %0b/%0b want 1/1", bus.cfg_tap_gnt, bus.ap_idle);
        end
        bus.cfg_tap_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ap_idle !== 1'b0 || bus.data_sel_zero !== 1'b1 || bus.data_WE !== 4'hF || bus.cfg_tap_gnt !== 1'b0) begin
            errors++;
            $display("FAIL pending_start_clear idle/zero/WE/gnt got %0b/%0b/%h/%0b want 0/1/f/0", bus.ap_idle, bus.data_sel_zero, bus.data_WE, bus.cfg_tap_gnt);
        end
        run_stream(3, 0, 0, 0);
    endtask

    task automatic test_reset_mid_run();
        int hs = 0, cyc = 0;
        bit hit = 0;
        gen_input(600, 1);
        bus.data_length = 600;
        bus.sm_tready = 1'b1;
        @(negedge clk); bus.ap_start = 1'b1;
        @(negedge clk); bus.ap_start = 1'b0;
        while (!hit && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (bus.sm_tvalid) hs++;
            if (hs == 5 && bus.mac_en) hit = 1;
            bus.ss_tvalid = bus.ss_tready && !hit;
            ss_tdata = xin[hs];
        end
        bus.ss_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_run_reach got 0 want 1");
        end
        checks++;
        if (bus.ap_idle !== 1'b1 || bus.tap_EN !== 1'b0 || bus.data_EN !== 1'b0 || bus.sm_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run idle/tapEN/dataEN/smv got %0b/%0b/%0b/%0b want 1/0/0/0", bus.ap_idle, bus.tap_EN, bus.data_EN, bus.sm_tvalid);
        end
        checks++;
        if ({bus.mac_en, bus.ss_tready, bus.ap_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_run_ctrl got %b want 000", {bus.mac_en, bus.ss_tready, bus.ap_done});
        end
        rst = 1'b0;
        gen_input(20, 1);
        run_stream(20, 1, 0, 0);
    endtask

`ifdef FIR_SCHED_TLAST_CHECK_EN
    task automatic test_tlast_check();
        gen_input(60, 1);
        run_stream(60, 1, 0, 1);
        checks++;
        if (tlast_err !== 1'b1) begin
            errors++;
            $display("FAIL tlast_early got %0b want 1", tlast_err);
        end
        run_stream(60, 1, 0, 0);
        checks++;
        if (tlast_err !== 1'b0) begin
            errors++;
            $display("FAIL tlast_correct got %0b want 0", tlast_err);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.ap_start = 1'b0;
        bus.data_length = 0;
        bus.ss_tvalid = 1'b0;
        bus.ss_tlast = 1'b0;
        bus.sm_tready = 1'b0;
        bus.cfg_tap_req = 1'b0;
        bus.cfg_tap_we = 1'b0;
        bus.cfg_tap_addr = '0;
        ss_tdata = 0;
        cfg_wdata = 0;
        test_reset();
        load_taps();
        test_full_run();
        test_ready_toggle();
        test_back_to_back();
        test_zero_len();
        test_cfg_arbiter();
        test_reset_mid_run();
`ifdef FIR_SCHED_TLAST_CHECK_EN
        test_tlast_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
